// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling, feeding a show-ahead byte FIFO and a level IRQ.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_fifo #(
  parameter int BAUD_DIV = 651,
  parameter int FIFO_AW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             UART_RX,
  input  logic             rd,
  input  logic             clr_err,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [FIFO_AW:0] rx_count,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err,
  output logic             irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] DIV_M1 = 16'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state;
  logic               sync1, sync2, armed;
  logic [15:0]        tick_cnt;
  logic [3:0]         os_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               par_bad;
  logic               tick, smp15, start_go;
  logic               push_req, push, pop, frame_set, overrun_set, parity_set;

  // Pop handshake: a byte leaves on any edge where rd=1 and rx_valid=1; rd while empty is ignored.
  always_comb begin
    tick        = (tick_cnt == 16'd0);
    smp15       = tick && (os_cnt == 4'd15);
    start_go    = (state == S_IDLE) && armed && !sync2;
    push_req    = (state == S_STOP) && smp15 && sync2 && !par_bad;
    frame_set   = (state == S_STOP) && smp15 && !sync2;
    pop         = rd && (rx_count != '0);
    push        = push_req && ((rx_count != FULL) || pop);
    overrun_set = push_req && !push;
`ifdef UART_RX_PARITY_EN
    parity_set  = (state == S_PARITY) && smp15 && (^{shreg, sync2});
`else
    parity_set  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      tick_cnt <= '0;
    end else begin
      sync1 <= UART_RX;
      sync2 <= sync1;
      if (start_go || tick) tick_cnt <= DIV_M1;
      else                  tick_cnt <= tick_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (tick) os_cnt <= os_cnt + 4'd1;
      case (state)
        S_IDLE: begin
          os_cnt <= '0;
          // A new start is only accepted after the line has been seen high once.
          if (sync2) armed <= 1'b1;
          else if (armed) begin
            state   <= S_START;
            armed   <= 1'b0;
            par_bad <= 1'b0;
          end
        end
        S_START: if (tick && os_cnt == 4'd7) begin
          os_cnt  <= '0;
          bit_cnt <= '0;
          state   <= sync2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (smp15) begin
          shreg   <= {sync2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state <= S_PARITY;
`else
          if (bit_cnt == 3'd7) state <= S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (smp15) begin
          par_bad <= parity_set;
          state   <= S_STOP;
        end
`endif
        S_STOP: if (smp15) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky flags: a new error event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun    <= overrun_set | (overrun & ~clr_err);
      frame_err  <= frame_set | (frame_err & ~clr_err);
      parity_err <= parity_set | (parity_err & ~clr_err);
    end
  end

  assign rx_data  = mem[rd_ptr];
  assign rx_valid = (rx_count != '0);
  assign irq      = rx_valid;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frame driver, queue-based reference model checked
// every cycle, and literal expectations from the test plan.
module tb_uart_rx_fifo;
  localparam int BD    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int BIT   = 16 * BD;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  localparam int EV_PUSH = 0, EV_FRAME = 1, EV_PARITY = 2;

  logic          clk = 1'b0, reset = 1'b0, UART_RX = 1'b1, rd = 1'b0, clr_err = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid, overrun, frame_err, parity_err, irq;
  logic [AW:0]   rx_count;
  int            checks = 0, errors = 0;

  uart_rx_fifo #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .UART_RX(UART_RX), .rd(rd), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // reference model: frame outcomes scheduled at the clock edge of each bit's midpoint sample
  typedef struct { int edge_at; int kind; logic [7:0] data; } ev_t;
  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  logic       m_overrun = 1'b0, m_frame = 1'b0, m_parity = 1'b0;
  int         edge_no = 0;
  bit         chk_en = 1'b0;

  // line falls before edge n: 2 sync edges, 8 ticks to mid start bit, 16 ticks per further bit
  function automatic int mid_edge(int n, int k);
    return n + 2 + 8 * BD + k * BIT;
  endfunction

  function automatic logic par(logic [7:0] d);
    return ^d;
  endfunction

  always @(posedge clk) begin
    bit push_req, fset, pset, oset, do_pop;
    logic [7:0] pd;
    edge_no++;
    push_req = 0; fset = 0; pset = 0; oset = 0; pd = 8'h00;
    while (ev_q.size() > 0 && ev_q[0].edge_at == edge_no) begin
      case (ev_q[0].kind)
        EV_PUSH:  begin push_req = 1; pd = ev_q[0].data; end
        EV_FRAME: fset = 1;
        default:  pset = 1;
      endcase
      void'(ev_q.pop_front());
    end
    if (!reset) begin
      exp_q.delete();
      ev_q.delete();
      m_overrun = 1'b0; m_frame = 1'b0; m_parity = 1'b0;
    end else begin
      do_pop = rd && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (push_req) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pd);
        else oset = 1;
      end
      m_overrun = oset | (m_overrun & ~clr_err);
      m_frame   = fset | (m_frame & ~clr_err);
      m_parity  = pset | (m_parity & ~clr_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_count", rx_count, exp_q.size());
      check("cmp_valid", rx_valid, exp_q.size() != 0);
      check("cmp_irq", irq, exp_q.size() != 0);
      if (exp_q.size() > 0) check("cmp_data", rx_data, exp_q[0]);
      check("cmp_overrun", overrun, m_overrun);
      check("cmp_frame_err", frame_err, m_frame);
      check("cmp_parity_err", parity_err, m_parity);
    end
  end

  // driver tasks
  task automatic schedule(input int n, input logic [7:0] d, input logic stop_b, input logic par_b);
    bit pbad;
    ev_t e;
    pbad = 0;
`ifdef UART_RX_PARITY_EN
    pbad = ^{d, par_b};
    if (pbad) begin
      e.edge_at = mid_edge(n, 9); e.kind = EV_PARITY; e.data = d;
      ev_q.push_back(e);
    end
`endif
    e.edge_at = mid_edge(n, STOP_IDX);
    e.data    = d;
    if (!stop_b) begin
      e.kind = EV_FRAME;
      ev_q.push_back(e);
    end else if (!pbad) begin
      e.kind = EV_PUSH;
      ev_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    @(negedge clk);
    schedule(edge_no + 1, d, stop_b, par_b);
    UART_RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    UART_RX = par_b;
    repeat (BIT) @(negedge clk);
`endif
    UART_RX = stop_b;
    repeat (BIT) @(negedge clk);
    UART_RX = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, par(d));
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, rx_data, exp);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pop_at(input int e);
    while (edge_no < e - 1) @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, rx_count, 0);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_data"}, rx_data, 8'h00);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_parity_err"}, parity_err, 0);
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_reset_values("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // single byte, then pop
    send_byte(8'hA5);
    check("a5_data", rx_data, 8'hA5);
    check("a5_count", rx_count, 1);
    check("a5_valid", rx_valid, 1);
    check("a5_irq", irq, 1);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("a5_pop_count", rx_count, 0);
    check("a5_pop_irq", irq, 0);

    // overflow: ninth byte dropped
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    check("ovf_count", rx_count, 8);
    check("ovf_flag", overrun, 1);
    for (int i = 1; i <= 8; i++) pop_check("ovf_data", 8'(i));
    check("ovf_empty", rx_count, 0);
    pulse_clr();
    check("ovf_clr", overrun, 0);

    // start-bit glitch of 4 oversample ticks
    @(negedge clk);
    UART_RX = 1'b0;
    repeat (4 * BD) @(negedge clk);
    UART_RX = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_count", rx_count, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overrun", overrun, 0);

    // framing error, clear, then a good byte
    send_frame(8'h3C, 1'b0, par(8'h3C));
    check("fe_flag", frame_err, 1);
    check("fe_count", rx_count, 0);
    pulse_clr();
    check("fe_clr", frame_err, 0);
    send_byte(8'h55);
    check("fe_next_count", rx_count, 1);
    pop_check("fe_next_data", 8'h55);

    // full FIFO with a pop on the push edge
    for (int i = 16; i < 24; i++) send_byte(8'(i));
    check("full_count", rx_count, 8);
    fork
      send_byte(8'h18);
      begin
        @(negedge clk);
        pop_at(mid_edge(edge_no + 1, STOP_IDX));
      end
    join
    check("full_pp_count", rx_count, 8);
    check("full_pp_overrun", overrun, 0);
    for (int i = 17; i <= 24; i++) pop_check("full_pp_data", 8'(i));

    // reset in the middle of a frame
    send_byte(8'h77);
    send_frame(8'h3C, 1'b0, par(8'h3C));
    check("pre_rst_count", rx_count, 1);
    check("pre_rst_frame_err", frame_err, 1);
    fork
      send_byte(8'hFF);
      begin
        @(negedge clk);
        repeat (200) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("mid_rst");
        reset = 1'b1;
      end
    join
    send_byte(8'h42);
    check("post_rst_count", rx_count, 1);
    pop_check("post_rst_data", 8'h42);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h42, 1'b1, ~par(8'h42));
    check("par_flag", parity_err, 1);
    check("par_count", rx_count, 0);
    pulse_clr();
    check("par_clr", parity_err, 0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front end feeding the Peripheral block's read path; the CPU consumes its bytes through `rd` at the UART data address.
- Converts the raw serial `UART_RX` line into 8N1 bytes using 16x oversampling.
- Queues received bytes in a show-ahead FIFO and raises a level IRQ while data is pending, so the CPU's interrupt path (`IRQ` → `PCSrc` exception vector) can drain it.

Parameters:
- BAUD_DIV, 651, `clk` cycles per oversample tick (100 MHz / (9600 × 16)); legal range 2..65535.
- FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW = 8 entries.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-low reset
- UART_RX  in  1  asynchronous serial input, idle high
- rd  in  1  pop request; 1-cycle pulse from the Peripheral address decode
- clr_err  in  1  clears sticky error flags
- rx_data  out  8  FIFO head byte, valid when rx_valid=1
- rx_valid  out  1  FIFO not empty
- rx_count  out  FIFO_AW+1  number of stored bytes, 0..2^FIFO_AW
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- frame_err  out  1  sticky: stop bit sampled as 0
- parity_err  out  1  sticky parity error; see Optional Feature
- irq  out  1  level interrupt, equals rx_valid

Behaviour:
- Reset (`reset`=0 at a rising edge of `clk`), effective the same edge, including mid-frame:
  - FSM returns to IDLE; tick counter, bit counter and shift register clear.
  - FIFO pointers zeroed; rx_count=0, rx_valid=0, irq=0, rx_data=8'h00.
  - All error flags 0.
  - Synchronizer flops preset to 1.
- Input synchronization: 2-flop synchronizer on UART_RX; the FSM sees only the synchronized value (2-cycle latency).
- Tick generator: down-counter emitting a 1-cycle tick every BAUD_DIV clocks. It is reloaded on the IDLE→START transition so the sample phase aligns to the start edge.
- FSM states and transitions:
  - IDLE: wait for synchronized RX = 0, then go to START and clear the tick count.
  - START: on the 8th tick (mid start bit), sample the line. If 1, treat it as a glitch and return to IDLE with no flags set. If 0, go to DATA with bit counter = 0.
  - DATA: every 16 ticks, sample and shift into the shift register LSB-first. After 8 bits go to STOP (or PARITY when RX_PARITY_EN is defined).
  - STOP: on the 16th tick, sample the line.
    - Sample = 1: push the byte.
    - Sample = 0: set frame_err and discard the byte.
    - In either case go to IDLE immediately; a line held low restarts a frame only after it returns high and falls again. IDLE requires one synchronized-high cycle before accepting a new start.
- FIFO:
  - Show-ahead: rx_data always presents mem[rd_ptr].
  - Push occurs at the stop-sample edge; rx_count and rx_valid update on that same edge.
  - Pop: rd=1 with rx_count>0 advances rd_ptr; the new head appears the following cycle.
  - rd=1 while empty is ignored; no state change, no flag.
  - Push while full with no pop: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop on the same edge when full: both occur, rx_count stays at 2^FIFO_AW, no overrun.
  - Push and pop on the same edge when empty: the push occurs and the pop is ignored.
  - Pointers wrap modulo 2^FIFO_AW; full/empty are distinguished by rx_count.
- Error flags: sticky until clr_err=1. If clr_err coincides with a new error event, the set wins.
- Latency: last rising edge of the stop-bit midpoint → rx_valid = 1 within 1 `clk` after the sample tick.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state between DATA and STOP samples a 9th bit after 16 ticks.
  - Even parity is checked over data plus parity bit.
  - On mismatch the byte is not pushed, parity_err is set, and the frame's stop bit is still checked for frame_err.
- Undefined: no PARITY state; parity_err is tied to 0.

Test Plan:
- Reset, then send 8'hA5 at BAUD_DIV=4 → rx_valid=1, rx_data=8'hA5, rx_count=1, irq=1; pulse rd → rx_count=0, irq=0 on the next cycle.
- Send 0x01..0x09 with no reads → rx_count=8, overrun=1; pop 8 times → data reads 0x01..0x08 in order, and 0x09 is absent.
- Hold RX low for 4 oversample ticks then high → FSM returns to IDLE; no push, no flags, rx_count=0.
- Send 8'h3C with stop bit forced to 0 → frame_err=1, rx_count unchanged; then clr_err=1 → frame_err=0; next byte 8'h55 is received normally.
- FIFO full with 0x10..0x17; issue rd on the same cycle as 0x18's push → no overrun, rx_count=8, pops yield 0x11..0x18.
- Assert reset mid-DATA of byte 8'hFF → all outputs at reset values next cycle; then 8'h42 is received correctly. With `UART_RX_PARITY_EN`, 8'h42 sent with odd parity → parity_err=1 and no push.
